// File: rtl/spi_rx_pkg.sv
// Shared definitions for the SPI frame receiver slice.
//   rx_state_t   : receive FSM states (IDLE, RECEIVE, DONE)
//   SYNC_STAGES  : depth of the per-line metastability synchroniser
//   cnt_width()  : bits needed for a counter that runs 0..max_count-1
package spi_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        DONE    = 2'd2
    } rx_state_t;

    localparam int SYNC_STAGES = 2;

    // Width of a counter covering 0..max_count-1; never narrower than one bit.
    function automatic int cnt_width(input int max_count);
        if (max_count <= 1) begin
            return 1;
        end else begin
            return $clog2(max_count);
        end
    endfunction

endpackage

// File: rtl/spi_line_filter.sv
// Synchroniser plus deglitch filter for one asynchronous input line.
// The filtered output follows the synchronised level only after that level
// has differed from the current output for FILTER_CYCLES consecutive samples.
//   i_clock  : system clock
//   i_reset  : synchronous, active-high reset (output returns to RESET_VALUE)
//   i_line   : raw asynchronous pin
//   o_line   : synchronised, filtered level
module spi_line_filter
    import spi_rx_pkg::*;
#(
    parameter int   FILTER_CYCLES = 3,
    parameter logic RESET_VALUE   = 1'b0
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_line,
    output logic o_line
);

    localparam logic [3:0] CNT_LAST = 4'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [3:0]             stable_cnt_r;
    logic                   filt_r;
    logic                   sync_s;

    assign sync_s = sync_r[SYNC_STAGES-1];
    assign o_line = filt_r;

    // Synchroniser chain and stability counter; a matching sample restarts the count.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sync_r       <= {SYNC_STAGES{RESET_VALUE}};
            stable_cnt_r <= 4'd0;
            filt_r       <= RESET_VALUE;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], i_line};
            if (sync_s != filt_r) begin
                if (stable_cnt_r == CNT_LAST) begin
                    filt_r       <= sync_s;
                    stable_cnt_r <= 4'd0;
                end else begin
                    stable_cnt_r <= stable_cnt_r + 4'd1;
                end
            end else begin
                stable_cnt_r <= 4'd0;
            end
        end
    end

endmodule

// File: rtl/spi_frame_rx.sv
// SPI slave frame receiver running entirely in the i_clock domain.
// Collects NUM_WORDS words of WORD_BITS bits per CS-low frame and publishes
// them atomically; a frame cut short by CS rising is flagged and discarded.
//   i_clock, i_reset          : system clock, synchronous active-high reset
//   i_spi_cs_n/clk/mosi       : raw asynchronous SPI pins
//   o_data                    : last complete frame, word k at [k*WORD_BITS +: WORD_BITS]
//   o_valid                   : one-cycle pulse when o_data updates
//   o_frame_error             : one-cycle pulse when a frame is aborted
//   o_busy                    : high while a frame is being received
module spi_frame_rx
    import spi_rx_pkg::*;
#(
    parameter int   WORD_BITS     = 16,
    parameter int   NUM_WORDS     = 4,
    parameter int   FILTER_CYCLES = 3,
    parameter logic CPOL          = 1'b0,
    parameter logic MSB_FIRST     = 1'b1
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic                           i_spi_cs_n,
    input  logic                           i_spi_clk,
    input  logic                           i_spi_mosi,
    output logic [WORD_BITS*NUM_WORDS-1:0] o_data,
    output logic                           o_valid,
    output logic                           o_frame_error,
    output logic                           o_busy
);

    localparam int BIT_W  = cnt_width(WORD_BITS);
    localparam int WORD_W = cnt_width(NUM_WORDS);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_BITS - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NUM_WORDS - 1);

    logic cs_filt_s;
    logic clk_filt_s;
    logic mosi_filt_s;

    spi_line_filter #(.FILTER_CYCLES(FILTER_CYCLES), .RESET_VALUE(1'b1)) u_cs_filter (
        .i_clock(i_clock), .i_reset(i_reset), .i_line(i_spi_cs_n), .o_line(cs_filt_s)
    );
    spi_line_filter #(.FILTER_CYCLES(FILTER_CYCLES), .RESET_VALUE(CPOL)) u_clk_filter (
        .i_clock(i_clock), .i_reset(i_reset), .i_line(i_spi_clk), .o_line(clk_filt_s)
    );
    spi_line_filter #(.FILTER_CYCLES(FILTER_CYCLES), .RESET_VALUE(1'b0)) u_mosi_filter (
        .i_clock(i_clock), .i_reset(i_reset), .i_line(i_spi_mosi), .o_line(mosi_filt_s)
    );

    logic cs_prev_r;
    logic clk_prev_r;
    logic sample_r;
    logic cs_fall_r;
    logic cs_rise_r;

    // Edge detection on the filtered lines, registered as single-cycle strobes.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cs_prev_r  <= 1'b1;
            clk_prev_r <= CPOL;
            sample_r   <= 1'b0;
            cs_fall_r  <= 1'b0;
            cs_rise_r  <= 1'b0;
        end else begin
            cs_prev_r  <= cs_filt_s;
            clk_prev_r <= clk_filt_s;
            sample_r   <= (clk_filt_s != CPOL) && (clk_prev_r == CPOL);
            cs_fall_r  <= (cs_filt_s == 1'b0) && (cs_prev_r == 1'b1);
            cs_rise_r  <= (cs_filt_s == 1'b1) && (cs_prev_r == 1'b0);
        end
    end

    rx_state_t             state_r;
    logic [WORD_BITS-1:0]  shift_r;
    logic [WORD_BITS-1:0]  shift_next_s;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic [WORD_W-1:0]     word_cnt_r;
    logic [WORD_BITS-1:0]  stage_r [NUM_WORDS];
    logic                  word_done_s;
    logic                  frame_done_s;

    // Shift register value after taking in the current filtered MOSI bit.
    always_comb begin
        shift_next_s = shift_r;
        if (MSB_FIRST) begin
            shift_next_s = {shift_r[WORD_BITS-2:0], mosi_filt_s};
        end else begin
            shift_next_s = {mosi_filt_s, shift_r[WORD_BITS-1:1]};
        end
    end

    assign word_done_s  = (bit_cnt_r == LAST_BIT);
    // Final edge wins over a simultaneous CS rise, so completion is checked first.
    assign frame_done_s = sample_r && word_done_s && (word_cnt_r == LAST_WORD);

    // Receive FSM with shift register, staging slots and registered outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r       <= IDLE;
            shift_r       <= {WORD_BITS{1'b0}};
            bit_cnt_r     <= {BIT_W{1'b0}};
            word_cnt_r    <= {WORD_W{1'b0}};
            o_data        <= {(WORD_BITS*NUM_WORDS){1'b0}};
            o_valid       <= 1'b0;
            o_frame_error <= 1'b0;
            o_busy        <= 1'b0;
            for (int k = 0; k < NUM_WORDS; k++) begin
                stage_r[k] <= {WORD_BITS{1'b0}};
            end
        end else begin
            o_valid       <= 1'b0;
            o_frame_error <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cs_fall_r) begin
                        shift_r    <= {WORD_BITS{1'b0}};
                        bit_cnt_r  <= {BIT_W{1'b0}};
                        word_cnt_r <= {WORD_W{1'b0}};
                        state_r    <= RECEIVE;
                        o_busy     <= 1'b1;
                    end else begin
                        o_busy     <= 1'b0;
                    end
                end
                RECEIVE: begin
                    if (frame_done_s) begin
                        stage_r[word_cnt_r] <= shift_next_s;
                        // Last slot comes straight from the shifter, the rest from staging.
                        for (int k = 0; k < NUM_WORDS; k++) begin
                            if (k == NUM_WORDS - 1) begin
                                o_data[k*WORD_BITS +: WORD_BITS] <= shift_next_s;
                            end else begin
                                o_data[k*WORD_BITS +: WORD_BITS] <= stage_r[k];
                            end
                        end
                        o_valid <= 1'b1;
                        o_busy  <= 1'b0;
                        state_r <= DONE;
                    end else if (cs_rise_r) begin
                        o_frame_error <= 1'b1;
                        o_busy        <= 1'b0;
                        state_r       <= IDLE;
                    end else if (sample_r) begin
                        shift_r <= shift_next_s;
                        if (word_done_s) begin
                            stage_r[word_cnt_r] <= shift_next_s;
                            word_cnt_r          <= word_cnt_r + WORD_W'(1);
                            bit_cnt_r           <= {BIT_W{1'b0}};
                        end else begin
                            bit_cnt_r           <= bit_cnt_r + BIT_W'(1);
                        end
                    end else begin
                        o_busy <= 1'b1;
                    end
                end
                DONE: begin
                    o_busy <= 1'b0;
                    if (cs_rise_r) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    o_busy  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_rx.sv
module tb_spi_frame_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cs1, sclk1, mosi1;
    logic        cs2, sclk2, mosi2;
    logic [63:0] data1;
    logic        v1, e1, b1;
    logic [23:0] data2;
    logic        v2, e2, b2;

    spi_frame_rx dut1 (
        .i_clock(clk), .i_reset(rst),
        .i_spi_cs_n(cs1), .i_spi_clk(sclk1), .i_spi_mosi(mosi1),
        .o_data(data1), .o_valid(v1), .o_frame_error(e1), .o_busy(b1)
    );

    spi_frame_rx #(
        .WORD_BITS(12), .NUM_WORDS(2), .FILTER_CYCLES(3), .CPOL(1'b1), .MSB_FIRST(1'b0)
    ) dut2 (
        .i_clock(clk), .i_reset(rst),
        .i_spi_cs_n(cs2), .i_spi_clk(sclk2), .i_spi_mosi(mosi2),
        .o_data(data2), .o_valid(v2), .o_frame_error(e2), .o_busy(b2)
    );

    int errors = 0;
    int checks = 0;

    // Pulse counters and a watch for o_data changing outside an o_valid cycle.
    int          vcnt1 = 0, ecnt1 = 0, vcnt2 = 0, ecnt2 = 0, stray1 = 0;
    logic [63:0] prev1 = 64'd0;
    logic        rst_d = 1'b1;
    always @(negedge clk) begin
        if (v1) vcnt1 <= vcnt1 + 1;
        if (e1) ecnt1 <= ecnt1 + 1;
        if (v2) vcnt2 <= vcnt2 + 1;
        if (e2) ecnt2 <= ecnt2 + 1;
        if (!rst && !rst_d && (data1 != prev1) && !v1) stray1 <= stray1 + 1;
        prev1 <= data1;
        rst_d <= rst;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int sel, input logic cs, input logic sc, input logic mo);
        if (sel == 1) begin
            cs1 = cs; sclk1 = sc; mosi1 = mo;
        end else begin
            cs2 = cs; sclk2 = sc; mosi2 = mo;
        end
    endtask

    // Drop CS and clock out nbits bits; glitch_kind 1 = SCLK glitch, 2 = MOSI glitch.
    task automatic send_frame(input int sel, input logic [63:0] frame, input int wb,
                              input int total, input int nbits, input logic cpol,
                              input logic msb, input int glitch_bit, input int glitch_kind);
        logic bitv;
        int   w, b, pos;
        drive(sel, 1'b0, cpol, 1'b0);
        tick(8);
        for (int n = 0; n < nbits; n++) begin
            w    = n / wb;
            b    = n % wb;
            pos  = msb ? (wb - 1 - b) : b;
            bitv = (n < total) ? frame[w*wb + pos] : 1'b0;
            if (n == 8) begin
                check($sformatf("busy_mid_frame_dut%0d", sel), (sel == 1) ? b1 : b2, 1'b1);
            end
            drive(sel, 1'b0, cpol, bitv);
            tick(8);
            if (glitch_bit == n && glitch_kind == 1) begin
                drive(sel, 1'b0, ~cpol, bitv);
                tick(2);
                drive(sel, 1'b0, cpol, bitv);
                tick(8);
            end
            drive(sel, 1'b0, ~cpol, bitv);
            tick(8);
            if (glitch_bit == n && glitch_kind == 2) begin
                drive(sel, 1'b0, ~cpol, ~bitv);
                tick(2);
                drive(sel, 1'b0, ~cpol, bitv);
                tick(8);
            end
        end
        drive(sel, 1'b0, cpol, 1'b0);
        tick(8);
    endtask

    typedef struct {
        string       name;
        logic [63:0] frame;
        int          nbits;
        int          glitch_bit;
        int          glitch_kind;
        logic        exp_busy_end;
        int          exp_valid;
        int          exp_err;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    int sv1, se1, sv2, se2;

    initial begin
        vecs[0] = '{"basic",       64'hFFFF_0000_ABCD_1234, 64, -1, 0, 1'b0, 1, 0, 64'hFFFF_0000_ABCD_1234};
        vecs[1] = '{"sclk_glitch", 64'h5A5A_0F0F_C3C3_1E1E, 64, 21, 1, 1'b0, 1, 0, 64'h5A5A_0F0F_C3C3_1E1E};
        vecs[2] = '{"mosi_glitch", 64'h8001_7FFE_2468_ACE0, 64, 37, 2, 1'b0, 1, 0, 64'h8001_7FFE_2468_ACE0};
        vecs[3] = '{"abort",       64'h1111_2222_3333_4444, 40, -1, 0, 1'b1, 0, 1, 64'h8001_7FFE_2468_ACE0};
        vecs[4] = '{"recover",     64'h0123_4567_89AB_CDEF, 64, -1, 0, 1'b0, 1, 0, 64'h0123_4567_89AB_CDEF};
        vecs[5] = '{"extra_edges", 64'hDEAD_BEEF_CAFE_F00D, 70, -1, 0, 1'b0, 1, 0, 64'hDEAD_BEEF_CAFE_F00D};

        rst = 1'b1;
        drive(1, 1'b1, 1'b0, 1'b0);
        drive(2, 1'b1, 1'b1, 1'b0);
        tick(5);
        rst = 1'b0;
        tick(10);
        check("reset_data1",  data1, 64'd0);
        check("reset_valid1", v1, 1'b0);
        check("reset_err1",   e1, 1'b0);
        check("reset_busy1",  b1, 1'b0);
        check("reset_data2",  data2, 24'd0);
        check("reset_busy2",  b2, 1'b0);

        for (int i = 0; i < 6; i++) begin
            sv1 = vcnt1;
            se1 = ecnt1;
            send_frame(1, vecs[i].frame, 16, 64, vecs[i].nbits, 1'b0, 1'b1,
                       vecs[i].glitch_bit, vecs[i].glitch_kind);
            check({vecs[i].name, "_busy_end"}, b1, vecs[i].exp_busy_end);
            drive(1, 1'b1, 1'b0, 1'b0);
            tick(20);
            check({vecs[i].name, "_valid_cnt"}, vcnt1 - sv1, vecs[i].exp_valid);
            check({vecs[i].name, "_err_cnt"},   ecnt1 - se1, vecs[i].exp_err);
            check({vecs[i].name, "_data"},      data1, vecs[i].exp_data);
            check({vecs[i].name, "_busy_idle"}, b1, 1'b0);
        end

        // Alternate configuration: 12-bit words, 2 words, CPOL=1, LSB first.
        sv2 = vcnt2;
        se2 = ecnt2;
        send_frame(2, 64'h3F1A5C, 12, 24, 24, 1'b1, 1'b0, -1, 0);
        check("cfg2_busy_end", b2, 1'b0);
        drive(2, 1'b1, 1'b1, 1'b0);
        tick(20);
        check("cfg2_valid_cnt", vcnt2 - sv2, 1);
        check("cfg2_err_cnt",   ecnt2 - se2, 0);
        check("cfg2_data",      data2, 24'h3F1A5C);

        // Reset in the middle of a frame, then a clean frame.
        sv1 = vcnt1;
        se1 = ecnt1;
        send_frame(1, 64'hAAAA_5555_F0F0_0F0F, 16, 64, 20, 1'b0, 1'b1, -1, 0);
        rst = 1'b1;
        tick(3);
        check("rst_mid_data",  data1, 64'd0);
        check("rst_mid_valid", v1, 1'b0);
        check("rst_mid_err",   e1, 1'b0);
        check("rst_mid_busy",  b1, 1'b0);
        drive(1, 1'b1, 1'b0, 1'b0);
        tick(10);
        rst = 1'b0;
        tick(20);
        check("rst_no_err",    ecnt1 - se1, 0);
        check("rst_no_valid",  vcnt1 - sv1, 0);
        send_frame(1, 64'h7E57_0000_FFFF_9C3A, 16, 64, 64, 1'b0, 1'b1, -1, 0);
        drive(1, 1'b1, 1'b0, 1'b0);
        tick(20);
        check("post_rst_valid", vcnt1 - sv1, 1);
        check("post_rst_err",   ecnt1 - se1, 0);
        check("post_rst_data",  data1, 64'h7E57_0000_FFFF_9C3A);

        check("data_stable_outside_valid", stray1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_frame_rx.md
# spi_frame_rx

Parametrised SPI slave frame receiver, the successor to the fixed 4×16-bit control-word receiver, with a configurable word width, word count and sampling edge. Synchronises and deglitches CS, SCLK and MOSI entirely in the i_clock domain, so there is no SPI-clocked logic. Assembles NUM_WORDS words per CS-low frame and publishes them atomically with a one-cycle valid strobe. Aborted frames are flagged and discarded. It sits between the MCU control SPI pins and the synthesis parameter registers.

## Interface
- WORD_BITS, 16: bits per word, 8..32.
- NUM_WORDS, 4: words per frame, 1..16.
- FILTER_CYCLES, 3: consecutive identical synchronised samples required before a filtered line changes, 1..15.
- CPOL, 0: SCLK idle level. Data is sampled on the filtered SCLK transition away from CPOL (CPOL=0 samples on the rising edge).
- MSB_FIRST, 1: 1 means the first bit received lands in the MSB of each word; 0 means LSB first.

- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_spi_cs_n  in  1  chip select, active low, asynchronous to i_clock.
- i_spi_clk  in  1  SPI clock, asynchronous.
- i_spi_mosi  in  1  SPI data, asynchronous.
- o_data  out  WORD_BITS*NUM_WORDS  last complete frame. Word k occupies bits [k*WORD_BITS +: WORD_BITS], and word 0 is the first received.
- o_valid  out  1  one-cycle pulse when o_data updates.
- o_frame_error  out  1  one-cycle pulse when a frame is aborted.
- o_busy  out  1  high while in RECEIVE.

## Operation
- Each input passes through a 2-flop synchroniser and then a per-line filter. Each line has its own stability counter, so lines are not filtered jointly.
- Filter behaviour:
  - The filtered value takes the synchronised value once that value has differed from it for FILTER_CYCLES consecutive samples.
  - Any sample that matches the current filtered value clears that line's counter.
- Reset values of the filtered lines: CS=1, SCLK=CPOL, MOSI=0.
- A sample edge is the filtered SCLK transition away from CPOL, registered as a single-cycle strobe.
- MOSI is taken from the filtered value in the cycle the strobe fires.
- States:
  - IDLE: on filtered CS falling, clear the shift register and bit/word counters, then go to RECEIVE.
  - RECEIVE: each sample edge shifts in one bit.
    - After WORD_BITS bits, the word is written to staging slot word_cnt and word_cnt increments.
    - After the last bit of word NUM_WORDS-1, load o_data from staging in the same cycle as the final slot write, pulse o_valid, and go to DONE.
    - If filtered CS rises first, pulse o_frame_error, leave o_data unchanged, and go to IDLE.
  - DONE: further sample edges are ignored. Filtered CS rising returns to IDLE with no error.
- A filtered CS rise in the same cycle as the final sample edge counts as frame completion: o_valid pulses and o_frame_error does not.
- A CS fall in IDLE with SCLK already away from CPOL does not produce a sample edge. The first edge counted is the next transition away from CPOL.
- Reset values: o_data=0, o_valid=0, o_frame_error=0, o_busy=0, state=IDLE, counters=0.
- Reset mid-frame discards the partial frame with no error pulse.

## Timing
- Each filtered transition occurs FILTER_CYCLES+2 i_clock edges after the first i_clock edge that samples the new pin level, provided the pin stays stable.
- o_valid asserts FILTER_CYCLES+4 i_clock edges after the first i_clock edge that samples the final sampling SCLK level.
- o_frame_error has the same latency, measured from the CS pin rising.
- Input requirements:
  - SCLK high and low phases ≥ FILTER_CYCLES+3 i_clock periods.
  - MOSI stable from FILTER_CYCLES+3 periods before the sampling edge until 1 period after it.
  - Pulses shorter than FILTER_CYCLES periods are rejected.
- o_data is stable at all times except the single update cycle. Consumers capture it when o_valid is high, or any time afterwards.

## Structure
- Package spi_rx_pkg holds:
  - the state enum (IDLE, RECEIVE, DONE);
  - the synchroniser depth constant (2);
  - the function computing counter widths via $clog2 of WORD_BITS and NUM_WORDS.
- Sub-module spi_line_filter (parameter FILTER_CYCLES, reset value; contains the synchroniser and stability counter) is instantiated three times.
- The top level holds the edge detect, FSM, shift register, staging array and output register.

## Test plan
- Default parameters, CPOL=0, MSB first, frame 0x1234, 0xABCD, 0x0000, 0xFFFF, SCLK period 16 clocks -> one o_valid pulse, o_data=0xFFFF_0000_ABCD_1234, o_frame_error stays 0.
- 2-clock glitch on SCLK mid-word (FILTER_CYCLES=3) -> no extra bit shifted and the frame decodes correctly. Repeat with a 2-clock MOSI glitch at a non-sampling time -> same result.
- CS deasserted after 2.5 words -> o_frame_error pulses once, o_data keeps the previous frame, and the next full frame decodes correctly.
- 70 SCLK edges in one CS-low window -> o_valid pulses once after edge 64, extra edges are ignored, and CS rise gives no error.
- WORD_BITS=12, NUM_WORDS=2, CPOL=1, MSB_FIRST=0, frame 0xA5C, 0x3F1 -> o_data=0x3F1_A5C.
- i_reset asserted after 20 bits, then released and a new full frame sent -> all outputs 0 during reset, no error pulse, new frame valid.
